// File: rtl/br_cdc_fifo_pkg.sv
// br_cdc_fifo_pkg: gray/binary conversion and count/address wrap helpers shared by the CDC FIFO cores
package br_cdc_fifo_pkg;
  localparam int MaxW = 32;
  function automatic logic [MaxW-1:0] gray2bin(input logic [MaxW-1:0] g);
    logic [MaxW-1:0] b;
    b[MaxW-1] = g[MaxW-1];
    for (int i = MaxW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic logic [MaxW-1:0] bin2gray(input logic [MaxW-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [MaxW-1:0] wrap_incr(input logic [MaxW-1:0] v, input logic [MaxW-1:0] limit);
    return (v == limit - 1) ? '0 : v + 1;
  endfunction
endpackage

// File: rtl/br_cdc_fifo_pop_staging.sv
// br_cdc_fifo_pop_staging: credit-tracked staging FIFO between RAM read data and the pop interface
module br_cdc_fifo_pop_staging #(
  parameter int StagingDepth = 1,
  parameter int Width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             issue,
  output logic             credit_ok,
  input  logic             wr_valid,
  input  logic [Width-1:0] wr_data,
  input  logic             pop_ready,
  output logic             pop_valid,
  output logic [Width-1:0] pop_data
);
  import br_cdc_fifo_pkg::*;
  localparam int PtrW = StagingDepth > 1 ? $clog2(StagingDepth) : 1;
  localparam int CntW = $clog2(StagingDepth + 1);
  logic [Width-1:0] mem [StagingDepth];
  logic [PtrW-1:0] head, tail;
  logic [CntW-1:0] count, inflight;
  logic beat;
  assign pop_valid = count != '0 && !clear;
  assign pop_data = mem[head];
  assign beat = pop_valid && pop_ready;
  assign credit_ok = !clear && ((32'(count) + 32'(inflight) < StagingDepth) || beat);
  always_ff @(posedge clk) begin
    if (wr_valid) mem[tail] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      inflight <= '0;
    end else begin
      assert (!wr_valid || issue || inflight != '0);
      assert (!wr_valid || beat || 32'(count) < StagingDepth);
      if (wr_valid) tail <= PtrW'(wrap_incr(32'(tail), StagingDepth));
      if (beat) head <= PtrW'(wrap_incr(32'(head), StagingDepth));
      count <= count + CntW'(wr_valid) - CntW'(beat);
      inflight <= inflight + CntW'(issue) - CntW'(wr_valid);
    end
  end
endmodule

// File: rtl/br_cdc_fifo_pop_ctrl_core.sv
// br_cdc_fifo_pop_ctrl_core: pop-side CDC FIFO core issuing RAM reads into a staging buffer behind ready/valid
module br_cdc_fifo_pop_ctrl_core #(
  parameter int Depth = 2,
  parameter int Width = 1,
  parameter int RamReadLatency = 0,
  parameter bit EnableAssertFinalNotValid = 1,
  localparam int AddrWidth = $clog2(Depth),
  localparam int CountWidth = $clog2(Depth + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pop_ready,
  output logic                  pop_valid,
  output logic [Width-1:0]      pop_data,
  output logic                  empty,
  output logic                  empty_next,
  output logic [CountWidth-1:0] items,
  output logic [CountWidth-1:0] items_next,
  output logic                  ram_rd_addr_valid,
  output logic [AddrWidth-1:0]  ram_rd_addr,
  input  logic                  ram_rd_data_valid,
  input  logic [Width-1:0]      ram_rd_data,
  input  logic [CountWidth-1:0] push_count_gray,
  output logic [CountWidth-1:0] pop_count_gray,
  input  logic                  reset_active_push,
  output logic                  reset_active_pop
);
  import br_cdc_fifo_pkg::*;
  logic [CountWidth-1:0] push_gray_q, push_count, push_count_next, pop_count, pop_count_next, rd_count, ram_items;
  logic beat, issue, credit_ok, hold_q;
  logic [Width-1:0] hold_data_q;
  assign push_count = CountWidth'(gray2bin(32'(push_gray_q)));
  assign push_count_next = reset_active_push ? '0 : CountWidth'(gray2bin(32'(push_count_gray)));
  assign beat = pop_valid && pop_ready;
  assign pop_count_next = reset_active_push ? '0 : pop_count + CountWidth'(beat);
  assign items = push_count - pop_count;
  assign items_next = push_count_next - pop_count_next;
  assign empty = items == '0;
  assign empty_next = items_next == '0;
  assign ram_items = push_count - rd_count;
  assign issue = ram_items != '0 && credit_ok;
  assign ram_rd_addr_valid = issue;
  br_cdc_fifo_pop_staging #(
    .StagingDepth(RamReadLatency + 1),
    .Width(Width)
  ) u_staging (
    .clk(clk),
    .rst_n(rst_n),
    .clear(reset_active_push),
    .issue(issue),
    .credit_ok(credit_ok),
    .wr_valid(ram_rd_data_valid),
    .wr_data(ram_rd_data),
    .pop_ready(pop_ready),
    .pop_valid(pop_valid),
    .pop_data(pop_data)
  );
  always_ff @(posedge clk) begin
    if (!rst_n || reset_active_push) begin
      push_gray_q <= '0;
      pop_count <= '0;
      pop_count_gray <= '0;
      rd_count <= '0;
      ram_rd_addr <= '0;
    end else begin
      push_gray_q <= push_count_gray;
      pop_count <= pop_count_next;
      pop_count_gray <= CountWidth'(bin2gray(32'(pop_count_next)));
      if (issue) begin
        rd_count <= rd_count + CountWidth'(1);
        ram_rd_addr <= AddrWidth'(wrap_incr(32'(ram_rd_addr), Depth));
      end
    end
  end
  always_ff @(posedge clk) reset_active_pop <= !rst_n;
  always_ff @(posedge clk) begin
    hold_q <= rst_n && !reset_active_push && pop_valid && !pop_ready;
    hold_data_q <= pop_data;
    if (rst_n && !reset_active_push) begin
      assert (32'(items) <= Depth);
      assert ($countones(push_count_gray ^ push_gray_q) <= 1);
      assert (CountWidth'(push_count_next - push_count) <= CountWidth'(1));
      if (hold_q) assert (pop_valid && pop_data == hold_data_q);
    end
  end
  if (EnableAssertFinalNotValid) begin : g_final_check
    final begin
      assert (!pop_valid && empty);
    end
  end
endmodule

// File: tb/tb_br_cdc_fifo_pop_ctrl_core.sv
// tb_br_cdc_fifo_pop_ctrl_core: directed self-checking bench for the pop-side CDC FIFO core
module tb_br_cdc_fifo_pop_ctrl_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int vectors = 0;
  int miscompares = 0;
  logic rdy4, pv4, e4, en4, av4, dv4, rap4in, rapop4;
  logic [7:0] pd4, dd4;
  logic [2:0] it4, itn4, pg4in, pg4out, pc4, pp4;
  logic [1:0] ad4, wp4;
  logic [7:0] mem4 [4];
  logic [7:0] q4 [$];
  logic rdy5, pv5, e5, en5, av5, dv5, rap5in, rapop5;
  logic [7:0] pd5, dd5;
  logic [2:0] it5, itn5, pg5in, pg5out, pc5, ad5, wp5;
  logic [7:0] mem5 [5];
  logic [7:0] q5 [$];
  br_cdc_fifo_pop_ctrl_core #(.Depth(4), .Width(8), .RamReadLatency(1)) u4 (
    .clk(clk), .rst_n(rst_n), .pop_ready(rdy4), .pop_valid(pv4), .pop_data(pd4),
    .empty(e4), .empty_next(en4), .items(it4), .items_next(itn4),
    .ram_rd_addr_valid(av4), .ram_rd_addr(ad4), .ram_rd_data_valid(dv4), .ram_rd_data(dd4),
    .push_count_gray(pg4in), .pop_count_gray(pg4out), .reset_active_push(rap4in), .reset_active_pop(rapop4)
  );
  br_cdc_fifo_pop_ctrl_core #(.Depth(5), .Width(8), .RamReadLatency(0)) u5 (
    .clk(clk), .rst_n(rst_n), .pop_ready(rdy5), .pop_valid(pv5), .pop_data(pd5),
    .empty(e5), .empty_next(en5), .items(it5), .items_next(itn5),
    .ram_rd_addr_valid(av5), .ram_rd_addr(ad5), .ram_rd_data_valid(dv5), .ram_rd_data(dd5),
    .push_count_gray(pg5in), .pop_count_gray(pg5out), .reset_active_push(rap5in), .reset_active_pop(rapop5)
  );
  always @(posedge clk) begin
    dv4 <= rst_n ? av4 : 1'b0;
    dd4 <= mem4[ad4];
  end
  assign dv5 = av5;
  assign dd5 = mem5[ad5];
  function automatic logic [2:0] g3(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push4(input logic [7:0] d);
    mem4[wp4] = d;
    wp4 = wp4 + 2'd1;
    pc4 = pc4 + 3'd1;
    pg4in = g3(pc4);
    q4.push_back(d);
  endtask
  task automatic push5(input logic [7:0] d);
    mem5[wp5] = d;
    wp5 = (wp5 == 3'd4) ? 3'd0 : wp5 + 3'd1;
    pc5 = pc5 + 3'd1;
    pg5in = g3(pc5);
    q5.push_back(d);
  endtask
  task automatic test_reset();
    rst_n = 1'b0; rdy4 = 1'b0; rdy5 = 1'b0; pg4in = '0; pg5in = '0; rap4in = 1'b0; rap5in = 1'b0;
    pc4 = '0; pp4 = '0; wp4 = '0; pc5 = '0; wp5 = '0;
    repeat (3) tick();
    vectors++; if (pv4 !== 1'b0) begin miscompares++; $display("FAIL reset_pop_valid got %b want 0", pv4); end
    vectors++; if (e4 !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", e4); end
    vectors++; if (en4 !== 1'b1) begin miscompares++; $display("FAIL reset_empty_next got %b want 1", en4); end
    vectors++; if (it4 !== 3'd0) begin miscompares++; $display("FAIL reset_items got %0d want 0", it4); end
    vectors++; if (av4 !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid got %b want 0", av4); end
    vectors++; if (ad4 !== 2'd0) begin miscompares++; $display("FAIL reset_rd_addr got %0d want 0", ad4); end
    vectors++; if (pg4out !== 3'd0) begin miscompares++; $display("FAIL reset_pop_gray got %0d want 0", pg4out); end
    vectors++; if (rapop4 !== 1'b1) begin miscompares++; $display("FAIL reset_active_pop got %b want 1", rapop4); end
    vectors++; if (pv5 !== 1'b0 || e5 !== 1'b1) begin miscompares++; $display("FAIL reset_d5 got valid=%b empty=%b want 0/1", pv5, e5); end
    rst_n = 1'b1;
    tick();
    vectors++; if (rapop4 !== 1'b0) begin miscompares++; $display("FAIL release_active_pop got %b want 0", rapop4); end
    vectors++; if (rapop5 !== 1'b0) begin miscompares++; $display("FAIL release_active_pop5 got %b want 0", rapop5); end
  endtask
  task automatic test_single();
    logic [7:0] exp;
    vectors++; if (av4 !== 1'b0) begin miscompares++; $display("FAIL single_idle got %b want 0", av4); end
    push4(8'hA5);
    #1;
    vectors++; if (itn4 !== 3'd1) begin miscompares++; $display("FAIL single_items_next got %0d want 1", itn4); end
    tick();
    vectors++; if (av4 !== 1'b1 || ad4 !== 2'd0) begin miscompares++; $display("FAIL single_read got v=%b a=%0d want 1/0", av4, ad4); end
    vectors++; if (it4 !== 3'd1 || e4 !== 1'b0) begin miscompares++; $display("FAIL single_items got %0d e=%b want 1/0", it4, e4); end
    tick();
    vectors++; if (pv4 !== 1'b0 || av4 !== 1'b0) begin miscompares++; $display("FAIL single_t2 got pv=%b av=%b want 0/0", pv4, av4); end
    tick();
    exp = q4.pop_front();
    vectors++; if (pv4 !== 1'b1 || pd4 !== exp) begin miscompares++; $display("FAIL single_pop got pv=%b d=%h want 1/%h", pv4, pd4, exp); end
    rdy4 = 1'b1;
    #1;
    vectors++; if (en4 !== 1'b1 || itn4 !== 3'd0) begin miscompares++; $display("FAIL single_next got en=%b in=%0d want 1/0", en4, itn4); end
    pp4 = pp4 + 3'd1;
    tick();
    rdy4 = 1'b0;
    vectors++; if (pg4out !== 3'd1 || e4 !== 1'b1 || pv4 !== 1'b0) begin miscompares++; $display("FAIL single_after got g=%0d e=%b pv=%b want 1/1/0", pg4out, e4, pv4); end
  endtask
  task automatic test_stream();
    logic [2:0] addrs [$];
    logic [2:0] ea;
    logic [7:0] exp;
    int pushed = 0, popped = 0, reads = 0, first = -1, last = -1;
    addrs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2};
    rdy5 = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (av5 === 1'b1) begin
        ea = (addrs.size() != 0) ? addrs.pop_front() : 3'd7;
        reads++;
        vectors++; if (ad5 !== ea) begin miscompares++; $display("FAIL stream_addr got %0d want %0d", ad5, ea); end
      end
      if (pv5 === 1'b1) begin
        exp = (q5.size() != 0) ? q5.pop_front() : 8'hxx;
        vectors++; if (pd5 !== exp) begin miscompares++; $display("FAIL stream_data got %h want %h", pd5, exp); end
        if (first < 0) first = c;
        last = c;
        popped++;
      end
      if (pushed < 8 && pushed - popped < 5) begin
        push5(8'h10 + 8'(pushed));
        pushed++;
      end
      tick();
    end
    rdy5 = 1'b0;
    vectors++; if (reads != 8 || popped != 8) begin miscompares++; $display("FAIL stream_count got r=%0d p=%0d want 8/8", reads, popped); end
    vectors++; if (last - first != 7) begin miscompares++; $display("FAIL stream_throughput got span %0d want 7", last - first); end
    vectors++; if (e5 !== 1'b1 || pv5 !== 1'b0) begin miscompares++; $display("FAIL stream_drained got e=%b pv=%b want 1/0", e5, pv5); end
  endtask
  task automatic test_backpressure();
    logic [7:0] exp;
    int reads = 0, n = 0;
    for (int i = 0; i < 10; i++) begin
      if (av4 === 1'b1) reads++;
      if (i < 4) push4(8'hB0 + 8'(i));
      tick();
    end
    vectors++; if (reads != 2) begin miscompares++; $display("FAIL bp_reads got %0d want 2", reads); end
    vectors++; if (it4 !== 3'd4) begin miscompares++; $display("FAIL bp_items got %0d want 4", it4); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (pv4 !== 1'b1 || pd4 !== 8'hB0) begin miscompares++; $display("FAIL bp_stable got pv=%b d=%h want 1/b0", pv4, pd4); end
      tick();
    end
    vectors++; if (av4 !== 1'b0) begin miscompares++; $display("FAIL bp_stall got %b want 0", av4); end
    rdy4 = 1'b1;
    for (int i = 0; i < 20 && n < 4; i++) begin
      if (pv4 === 1'b1) begin
        exp = (q4.size() != 0) ? q4.pop_front() : 8'hxx;
        vectors++; if (pd4 !== exp) begin miscompares++; $display("FAIL bp_drain got %h want %h", pd4, exp); end
        n++;
        pp4 = pp4 + 3'd1;
      end
      tick();
    end
    rdy4 = 1'b0;
    vectors++; if (n != 4 || it4 !== 3'd0) begin miscompares++; $display("FAIL bp_drained got n=%0d items=%0d want 4/0", n, it4); end
  endtask
  task automatic test_wrap();
    logic [7:0] exp;
    int pushed = 0, popped = 0;
    for (int c = 0; c < 80 && popped < 11; c++) begin
      rdy4 = (c % 3) != 0;
      vectors++; if (it4 !== 3'(pc4 - pp4)) begin miscompares++; $display("FAIL wrap_items got %0d want %0d", it4, 3'(pc4 - pp4)); end
      vectors++; if (pg4out !== g3(pp4)) begin miscompares++; $display("FAIL wrap_pop_gray got %0d want %0d", pg4out, g3(pp4)); end
      if (pv4 === 1'b1 && rdy4) begin
        exp = (q4.size() != 0) ? q4.pop_front() : 8'hxx;
        vectors++; if (pd4 !== exp) begin miscompares++; $display("FAIL wrap_data got %h want %h", pd4, exp); end
        popped++;
        pp4 = pp4 + 3'd1;
      end
      if (pushed < 11 && 3'(pc4 - pp4) < 3'd4) begin
        push4(8'h40 + 8'(pushed));
        pushed++;
      end
      tick();
    end
    rdy4 = 1'b0;
    vectors++; if (popped != 11) begin miscompares++; $display("FAIL wrap_done got %0d want 11", popped); end
    vectors++; if (pg4out !== 3'd0 || e4 !== 1'b1) begin miscompares++; $display("FAIL wrap_final got g=%0d e=%b want 0/1", pg4out, e4); end
  endtask
  task automatic test_remote_reset();
    logic [7:0] exp;
    int n = 0;
    for (int i = 0; i < 3; i++) begin
      push4(8'hC0 + 8'(i));
      tick();
    end
    repeat (4) tick();
    vectors++; if (pv4 !== 1'b1 || pd4 !== 8'hC0) begin miscompares++; $display("FAIL rr_pre got pv=%b d=%h want 1/c0", pv4, pd4); end
    rap4in = 1'b1; pg4in = '0; pc4 = '0; pp4 = '0; wp4 = '0;
    q4.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (pv4 !== 1'b0 || av4 !== 1'b0 || it4 !== 3'd0 || pg4out !== 3'd0) begin miscompares++; $display("FAIL rr_held got pv=%b av=%b it=%0d g=%0d want 0/0/0/0", pv4, av4, it4, pg4out); end
    end
    rap4in = 1'b0;
    tick();
    vectors++; if (pv4 !== 1'b0 || it4 !== 3'd0 || e4 !== 1'b1 || ad4 !== 2'd0) begin miscompares++; $display("FAIL rr_release got pv=%b it=%0d e=%b a=%0d want 0/0/1/0", pv4, it4, e4, ad4); end
    push4(8'hD7);
    rdy4 = 1'b1;
    for (int i = 0; i < 10 && n == 0; i++) begin
      tick();
      if (pv4 === 1'b1) begin
        exp = q4.pop_front();
        vectors++; if (pd4 !== exp) begin miscompares++; $display("FAIL rr_data got %h want %h", pd4, exp); end
        n = 1;
        pp4 = pp4 + 3'd1;
      end
    end
    tick();
    rdy4 = 1'b0;
    vectors++; if (n != 1) begin miscompares++; $display("FAIL rr_recover got %0d pops want 1", n); end
    vectors++; if (pg4out !== 3'd1 || e4 !== 1'b1) begin miscompares++; $display("FAIL rr_after got g=%0d e=%b want 1/1", pg4out, e4); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_wrap();
    test_remote_reset();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout reached without finishing");
    $fatal(1);
  end
endmodule

// File: doc/br_cdc_fifo_pop_ctrl_core.md
Name: br_cdc_fifo_pop_ctrl_core

Overview:
- Single-clock pop-side core of the 1R1W CDC FIFO controller; receiver counterpart of the push-side core.
- Consumes the push-domain gray count (already synchronized into this domain), issues RAM reads and prefetches into a staging buffer.
- Presents ready/valid pop output; returns its own gray pop count and reset-active flag to the push side.

Parameters:
- Depth, 2, FIFO entries; must be >= 2.
- Width, 1, bits per entry; must be >= 1.
- RamReadLatency, 0, cycles from ram_rd_addr_valid to ram_rd_data_valid; must be >= 0.
- EnableAssertFinalNotValid, 1, assert pop_valid=0 and empty=1 at end of test.
- AddrWidth (localparam), $clog2(Depth).
- CountWidth (localparam), $clog2(Depth+1).

Ports:
- clk  in  1  posedge clock.
- rst_n  in  1  synchronous, active-low reset.
- pop_ready  in  1  consumer ready.
- pop_valid  out  1  staging buffer holds an entry.
- pop_data  out  Width  head entry of staging buffer.
- empty  out  1  items==0.
- empty_next  out  1  next-cycle empty.
- items  out  CountWidth  entries pushed and not yet popped, as seen locally.
- items_next  out  CountWidth  next-cycle items.
- ram_rd_addr_valid  out  1  RAM read request.
- ram_rd_addr  out  AddrWidth  RAM read address.
- ram_rd_data_valid  in  1  RAM read data return.
- ram_rd_data  in  Width  RAM read data.
- push_count_gray  in  CountWidth  synchronized push count (gray).
- pop_count_gray  out  CountWidth  registered pop count (gray) sent to push side.
- reset_active_push  in  1  synchronized push-side reset flag.
- reset_active_pop  out  1  local reset flag sent to push side.

Behaviour:
- Reset (rst_n=0 at posedge) sets pop_valid=0, empty=1, empty_next=1, items=0, items_next=0, ram_rd_addr_valid=0, ram_rd_addr=0, pop_count_gray=0, reset_active_pop=1. The staging buffer is emptied.
- reset_active_pop is a flop: 1 during reset, 0 from the first cycle after rst_n=1.
- push_count_gray is registered once, then converted gray->binary into push_count.
- Counters wrap modulo 2^CountWidth. items = push_count - pop_count (mod 2^CountWidth). items is never greater than Depth; assert this.
- Pop beat = pop_valid & pop_ready. On a pop beat, pop_count increments and pop_count_gray updates registered, in the same cycle the beat occurs.
- RAM entries stay owned by the pop side until popped, so staging occupancy counts against FIFO capacity.
- rd_count tracks reads issued. ram_items = push_count - rd_count.
- A read is issued (ram_rd_addr_valid=1) when ram_items>0 and staging credit>0. Reads are combinational from registered state.
- Each issued read: rd_count increments and ram_rd_addr advances. The address wraps from Depth-1 to 0, which also covers non-power-of-2 Depth.
- Staging buffer: StagingDepth = RamReadLatency+1, FIFO order. Credit is decremented on issue and returned on a pop beat.
- Read data arriving with no staging slot free is impossible. Assert this, and assert ram_rd_data_valid only follows an issued read.
- First-word latency: push_count_gray change at cycle t gives ram_rd_addr_valid at t+1 and pop_valid at t+2+RamReadLatency.
- Throughput: 1 pop/cycle sustained when ram_items>0.
- Simultaneous push-count increase and pop beat in one cycle: items_next = items + delta_push - 1.
- While reset_active_push=1: pop_valid=0, no reads issued, all counters and staging held at reset values. The push side resets together with this block.
- pop_valid/pop_data are stable until a pop beat. Assert this.
- Gray input checks: push_count_gray changes by at most one bit per cycle, and the decoded count is monotonic mod 2^CountWidth.

Decomposition:
- br_cdc_fifo_pkg: gray2bin and bin2gray functions (parameterized width) plus count/address wrap helpers. Shared with the push-side core.
- Sub-module br_cdc_fifo_pop_staging holds the staging FIFO. It takes StagingDepth and Width, and provides credit tracking, the push-from-RAM port and the ready/valid pop port.

Test Plan:
- Reset: rst_n=0 for 3 cycles with push_count_gray=0 -> pop_valid=0, empty=1, pop_count_gray=0, reset_active_pop=1; reset_active_pop=0 on the cycle after release.
- Single entry, Depth=4, RamReadLatency=1: push_count_gray 0->1 at t -> ram_rd_addr_valid=1 with addr=0 at t+1; pop_valid at t+3; pop with pop_ready=1 -> pop_count_gray=1, empty=1.
- Full stream, Depth=5, latency 0: gray sequence 1..5, pop_ready=1 -> 5 pops in order. Addresses read are 0,1,2,3,4, then wrap to 0 on the next batch.
- Backpressure: 4 items and pop_ready=0 -> exactly StagingDepth reads issued, then issue stalls; pop_data stable; items=4.
- Wrap: 2^CountWidth+3 total transfers at Depth=4 -> counts wrap 7->0 correctly; items never above 4; data order preserved.
- Remote reset: reset_active_push=1 mid-stream -> pop_valid=0 the next cycle, no reads issued, counters held at 0 until it deasserts.
